// File: rtl/user_button_event_queue_if.sv
// Button-event bus between the debounced producers/host and the event queue.
// drop_count exists only when BUTTON_EVENT_DROP_EN is defined.
interface user_button_event_queue_if #(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned FIFO_DEPTH  = 8
);
  localparam int unsigned CODE_W = $clog2(NUM_BUTTONS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_BUTTONS-1:0] press_activated;
  logic [NUM_BUTTONS-1:0] press_accepted;
  logic                   event_valid;
  logic [CODE_W-1:0]      event_code;
  logic                   event_read;
  logic [CNT_W-1:0]       fifo_count;
`ifdef BUTTON_EVENT_DROP_EN
  logic [7:0]             drop_count;

  modport master (
    output press_activated, event_read,
    input  press_accepted, event_valid, event_code, fifo_count, drop_count
  );
  modport slave (
    input  press_activated, event_read,
    output press_accepted, event_valid, event_code, fifo_count, drop_count
  );
`else
  modport master (
    output press_activated, event_read,
    input  press_accepted, event_valid, event_code, fifo_count
  );
  modport slave (
    input  press_activated, event_read,
    output press_accepted, event_valid, event_code, fifo_count
  );
`endif
endinterface

// File: rtl/user_button_event_queue.sv
// Arbitrates button press handshakes and queues accepted button indices in a show-ahead FIFO.
// Define BUTTON_EVENT_DROP_EN to drop (and count) presses arriving while the FIFO is full.
module user_button_event_queue #(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input logic                      clock,
  input logic                      reset_n,
  user_button_event_queue_if.slave io_bus
);
  localparam int unsigned CODE_W = $clog2(NUM_BUTTONS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCEPT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                 r_state,  w_state_nxt;
  logic [CODE_W-1:0]      r_sel,    w_sel_nxt;
  logic [NUM_BUTTONS-1:0] r_ack,    w_ack_nxt;
  logic [CODE_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [CNT_W-1:0]       r_count,  w_count_nxt;
  logic                   r_valid;
  logic [CODE_W-1:0]      r_code,   w_code_nxt;
  logic                   w_req_any;
  logic [CODE_W-1:0]      w_req_idx;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
`ifdef BUTTON_EVENT_DROP_EN
  logic                   w_drop;
  logic [7:0]             r_drop;
`endif

  // Lowest-index pending request wins
  always_comb begin
    w_req_any = 1'b0;
    w_req_idx = '0;
    for (int i = int'(NUM_BUTTONS) - 1; i >= 0; i--) begin
      if (io_bus.press_activated[i]) begin
        w_req_any = 1'b1;
        w_req_idx = CODE_W'(i);
      end
    end
  end

  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = io_bus.event_read && (r_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
`ifdef BUTTON_EVENT_DROP_EN
    w_drop      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          if (!w_full) begin
            w_push                 = 1'b1;
            w_sel_nxt              = w_req_idx;
            w_ack_nxt              = '0;
            w_ack_nxt[w_req_idx]   = 1'b1;
            w_state_nxt            = ST_ACCEPT;
          end
`ifdef BUTTON_EVENT_DROP_EN
          else begin
            w_drop                 = 1'b1;
            w_sel_nxt              = w_req_idx;
            w_ack_nxt              = '0;
            w_ack_nxt[w_req_idx]   = 1'b1;
            w_state_nxt            = ST_ACCEPT;
          end
`endif
        end
      end
      ST_ACCEPT: begin
        if (!io_bus.press_activated[r_sel]) begin
          w_ack_nxt   = '0;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default: begin
        w_ack_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Head lookahead: the registered code must already reflect this edge's push/pop
  always_comb begin
    w_rd_nxt = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_push && (r_wr_ptr == w_rd_nxt)) w_code_nxt = w_req_idx;
    else                                  w_code_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_ack    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_code   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_ack    <= w_ack_nxt;
      r_wr_ptr <= w_push ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      r_code   <= w_code_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_req_idx;
  end

`ifdef BUTTON_EVENT_DROP_EN
  always_ff @(posedge clock) begin
    if (!reset_n)                        r_drop <= '0;
    else if (w_drop && r_drop != 8'hFF)  r_drop <= r_drop + 8'd1;
  end
  assign io_bus.drop_count = r_drop;
`endif

  assign io_bus.press_accepted = r_ack;
  assign io_bus.event_valid    = r_valid;
  assign io_bus.event_code     = r_code;
  assign io_bus.fifo_count     = r_count;
endmodule

// File: tb/tb_user_button_event_queue.sv
// Scoreboard bench for user_button_event_queue; follows BUTTON_EVENT_DROP_EN like the RTL.
module tb_user_button_event_queue;
  localparam int unsigned NB    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NB-1:0] press;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            exp_q[$];

  user_button_event_queue_if #(.NUM_BUTTONS(NB), .FIFO_DEPTH(DEPTH)) bus();
  user_button_event_queue #(.NUM_BUTTONS(NB), .FIFO_DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .io_bus (bus)
  );

  assign bus.press_activated = press;
  always #5 clock = ~clock;

  // One cycle; the producer drops a request one edge after it samples its ack
  task automatic tick(input bit release_en);
    logic [NB-1:0] seen;
    seen = bus.press_accepted;
    @(posedge clock);
    #1;
    cyc++;
    if (release_en) press = press & ~seen;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((press !== '0 || bus.press_accepted !== '0) && n < 40) begin
      tick(1);
      n++;
    end
    total++;
    if (n == 40) begin
      bad++;
      $display("FAIL wait_idle: timeout press=%b ack=%b", press, bus.press_accepted);
    end
    tick(1);
  endtask

  task automatic pop_one(output logic v, output logic [CW-1:0] c);
    v = bus.event_valid;
    c = bus.event_code;
    bus.event_read = 1'b1;
    tick(1);
    bus.event_read = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(0);
    tick(0);
    total += 4;
    if (bus.press_accepted !== '0) begin bad++; $display("FAIL reset_ack: got %b want 0", bus.press_accepted); end
    if (bus.event_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %b want 0", bus.event_valid); end
    if (bus.event_code !== '0)     begin bad++; $display("FAIL reset_code: got %0d want 0", bus.event_code); end
    if (bus.fifo_count !== '0)     begin bad++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
`ifdef BUTTON_EVENT_DROP_EN
    total++;
    if (bus.drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
`endif
    reset_n = 1'b1;
    tick(0);
  endtask

  task automatic test_single();
    logic v; logic [CW-1:0] c; int e;
    press[2] = 1'b1;
    exp_q.push_back(2);
    tick(1);
    total += 4;
    if (bus.press_accepted !== 4'b0100) begin bad++; $display("FAIL single_ack_n1: got %b want 0100", bus.press_accepted); end
    if (bus.event_valid !== 1'b1)       begin bad++; $display("FAIL single_valid: got %b want 1", bus.event_valid); end
    if (bus.event_code !== 2'd2)        begin bad++; $display("FAIL single_code: got %0d want 2", bus.event_code); end
    if (bus.fifo_count !== 4'd1)        begin bad++; $display("FAIL single_count: got %0d want 1", bus.fifo_count); end
    tick(1);
    total++;
    if (bus.press_accepted !== 4'b0100) begin bad++; $display("FAIL single_ack_n2: got %b want 0100", bus.press_accepted); end
    tick(1);
    total++;
    if (bus.press_accepted !== 4'b0000) begin bad++; $display("FAIL single_ack_n3: got %b want 0000", bus.press_accepted); end
    tick(1);
    pop_one(v, c);
    e = exp_q.pop_front();
    total += 3;
    if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL single_pop: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
    if (bus.fifo_count !== 4'd0)    begin bad++; $display("FAIL single_pop_count: got %0d want 0", bus.fifo_count); end
    if (bus.event_valid !== 1'b0)   begin bad++; $display("FAIL single_pop_valid: got %b want 0", bus.event_valid); end
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] prev; int order[$]; int stamp[$]; int want[3];
    logic v; logic [CW-1:0] c; int e;
    want = '{0, 1, 3};
    press = press | 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    prev = bus.press_accepted;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      total++;
      if ($countones(bus.press_accepted) > 1) begin bad++; $display("FAIL sim_onehot: got %b want at most one bit", bus.press_accepted); end
      for (int i = 0; i < int'(NB); i++)
        if (bus.press_accepted[i] && !prev[i]) begin order.push_back(i); stamp.push_back(cyc); end
      prev = bus.press_accepted;
      if (press == '0 && bus.press_accepted == '0) break;
    end
    total++;
    if (order.size() != 3) begin bad++; $display("FAIL sim_grants: got %0d want 3", order.size()); end
    for (int j = 0; j < order.size() && j < 3; j++) begin
      total++;
      if (order[j] != want[j]) begin bad++; $display("FAIL sim_order: got ch%0d want ch%0d", order[j], want[j]); end
      if (j > 0) begin
        total++;
        if (stamp[j] - stamp[j-1] < 4) begin bad++; $display("FAIL sim_spacing: got %0d want >=4", stamp[j] - stamp[j-1]); end
      end
    end
    tick(1);
    for (int j = 0; j < 3; j++) begin
      pop_one(v, c);
      e = exp_q.pop_front();
      total++;
      if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL sim_pop: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
    end
  endtask

  task automatic test_fill();
    logic v; logic [CW-1:0] c; int e; int n;
    for (int k = 0; k < int'(DEPTH); k++) begin
      press[k % 4] = 1'b1;
      exp_q.push_back(k % 4);
      wait_idle();
    end
    total++;
    if (bus.fifo_count !== 4'd8) begin bad++; $display("FAIL fill_count: got %0d want 8", bus.fifo_count); end
    press[2] = 1'b1;
`ifndef BUTTON_EVENT_DROP_EN
    repeat (6) tick(1);
    total += 2;
    if (bus.press_accepted !== '0) begin bad++; $display("FAIL full_noack: got %b want 0000", bus.press_accepted); end
    if (bus.fifo_count !== 4'd8)   begin bad++; $display("FAIL full_hold_count: got %0d want 8", bus.fifo_count); end
    pop_one(v, c);
    e = exp_q.pop_front();
    total++;
    if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL full_pop: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
    exp_q.push_back(2);
    n = 0;
    while (!bus.press_accepted[2] && n < 10) begin tick(1); n++; end
    total += 2;
    if (n == 10) begin bad++; $display("FAIL full_late_ack: got timeout want ack on ch2"); end
    if (bus.fifo_count !== 4'd8) begin bad++; $display("FAIL full_refill_count: got %0d want 8", bus.fifo_count); end
`else
    n = 0;
    while (!bus.press_accepted[2] && n < 10) begin tick(1); n++; end
    total += 3;
    if (n == 10) begin bad++; $display("FAIL drop_ack: got timeout want ack on ch2"); end
    if (bus.fifo_count !== 4'd8) begin bad++; $display("FAIL drop_count_fifo: got %0d want 8", bus.fifo_count); end
    if (bus.drop_count !== 8'd1) begin bad++; $display("FAIL drop_counter: got %0d want 1", bus.drop_count); end
`endif
    wait_idle();
    while (exp_q.size() > 0) begin
      pop_one(v, c);
      e = exp_q.pop_front();
      total++;
      if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL fill_drain: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
    end
    total++;
    if (bus.fifo_count !== 4'd0) begin bad++; $display("FAIL fill_empty: got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_push_pop_same();
    logic v; logic [CW-1:0] c; int e; int chs[7];
    chs = '{1, 2, 3, 1, 2, 3, 0};
    for (int round = 0; round < 2; round++) begin
      int target;
      target = (round == 0) ? 3 : 7;
      while (exp_q.size() < target) begin
        press[chs[exp_q.size()]] = 1'b1;
        exp_q.push_back(chs[exp_q.size()]);
        wait_idle();
      end
      press[0] = 1'b1;
      bus.event_read = 1'b1;
      v = bus.event_valid;
      c = bus.event_code;
      tick(1);
      bus.event_read = 1'b0;
      e = exp_q.pop_front();
      exp_q.push_back(0);
      total += 2;
      if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL pp_head: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
      if (bus.fifo_count !== CW'(0) + 4'(target)) begin bad++; $display("FAIL pp_count: got %0d want %0d", bus.fifo_count, target); end
      wait_idle();
    end
  endtask

  task automatic test_wrap();
    logic v; logic [CW-1:0] c; int e; int r; int sz; int ch;
    for (int op = 0; op < 20; op++) begin
      r  = int'($urandom_range(0, 2));
      sz = exp_q.size();
      ch = int'($urandom_range(0, NB - 1));
      if (sz == 0 || (r == 0 && sz < int'(DEPTH))) begin
        press[ch] = 1'b1;
        exp_q.push_back(ch);
        wait_idle();
      end else if (r == 1 || sz == int'(DEPTH)) begin
        pop_one(v, c);
        e = exp_q.pop_front();
        total++;
        if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL wrap_pop: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
      end else begin
        press[ch] = 1'b1;
        bus.event_read = 1'b1;
        v = bus.event_valid;
        c = bus.event_code;
        tick(1);
        bus.event_read = 1'b0;
        e = exp_q.pop_front();
        exp_q.push_back(ch);
        total += 2;
        if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL wrap_pp_head: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
        if (bus.fifo_count !== 4'(sz)) begin bad++; $display("FAIL wrap_pp_count: got %0d want %0d", bus.fifo_count, sz); end
        wait_idle();
      end
    end
    total++;
    if (bus.fifo_count !== 4'(exp_q.size())) begin bad++; $display("FAIL wrap_count: got %0d want %0d", bus.fifo_count, exp_q.size()); end
    while (exp_q.size() > 0) begin
      pop_one(v, c);
      e = exp_q.pop_front();
      total++;
      if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL wrap_drain: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
    end
  endtask

  task automatic test_pop_empty();
    logic v; logic [CW-1:0] c; int e;
    bus.event_read = 1'b1;
    repeat (3) tick(1);
    bus.event_read = 1'b0;
    total += 2;
    if (bus.fifo_count !== 4'd0)  begin bad++; $display("FAIL empty_count: got %0d want 0", bus.fifo_count); end
    if (bus.event_valid !== 1'b0) begin bad++; $display("FAIL empty_valid: got %b want 0", bus.event_valid); end
    press[3] = 1'b1;
    exp_q.push_back(3);
    wait_idle();
    pop_one(v, c);
    e = exp_q.pop_front();
    total += 2;
    if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL empty_then_press: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
    if (bus.fifo_count !== 4'd0)    begin bad++; $display("FAIL empty_after_pop: got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_reset_accept();
    logic v; logic [CW-1:0] c; int e;
    press[1] = 1'b1;
    tick(0);
    total++;
    if (bus.press_accepted !== 4'b0010) begin bad++; $display("FAIL rst_pre_ack: got %b want 0010", bus.press_accepted); end
    reset_n = 1'b0;
    tick(0);
    reset_n = 1'b1;
    exp_q.delete();
    total += 4;
    if (bus.press_accepted !== '0) begin bad++; $display("FAIL rst_ack: got %b want 0", bus.press_accepted); end
    if (bus.event_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", bus.event_valid); end
    if (bus.event_code !== '0)     begin bad++; $display("FAIL rst_code: got %0d want 0", bus.event_code); end
    if (bus.fifo_count !== '0)     begin bad++; $display("FAIL rst_count: got %0d want 0", bus.fifo_count); end
    exp_q.push_back(1);
    tick(1);
    total += 3;
    if (bus.press_accepted !== 4'b0010) begin bad++; $display("FAIL rst_reaccept: got %b want 0010", bus.press_accepted); end
    if (bus.fifo_count !== 4'd1)        begin bad++; $display("FAIL rst_refill: got %0d want 1", bus.fifo_count); end
    if (bus.event_code !== 2'd1)        begin bad++; $display("FAIL rst_code1: got %0d want 1", bus.event_code); end
    wait_idle();
    pop_one(v, c);
    e = exp_q.pop_front();
    total++;
    if (v !== 1'b1 || c !== CW'(e)) begin bad++; $display("FAIL rst_pop: got v=%b code=%0d want v=1 code=%0d", v, c, e); end
  endtask

  initial begin
    reset_n        = 1'b0;
    press          = '0;
    bus.event_read = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fill();
    test_push_pop_same();
    test_wrap();
    test_pop_empty();
    test_reset_accept();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
